// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-wide data memory sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmem_pkg;

    // Request size encodings; 2'b11 is reserved and handled as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The memory drops writes whose data_in is all-zero, so this bit is
    // always set on store beats to let 8'h00 bytes land.
    localparam int MEM_WE_GUARD_BIT = 8;

    // Number of single-byte memory beats for a request size.
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: beat_count = 3'd1;
            SZ_HALF: beat_count = 3'd2;
            default: beat_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_word_sequencer_if.sv
// Request/response and memory-side signals of the data memory sequencer.
// Latency: n/a (wiring only).
// Backpressure: req_ready/busy from the sequencer stall the requester.
// Ports: req_* (request), resp_* (completion), busy (pipeline stall),
//        mem_* (byte-wide memory: write, addr, wdata out; rdata in).
interface dmem_word_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              busy;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [7:0]        mem_rdata;

    // Sequencer view.
    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_write, mem_addr, mem_wdata
    );

    // Requester plus memory view.
    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_byte_lane_mux.sv
// Picks the store byte for beat cnt of an n_beats transfer (big-endian).
// Latency: combinational.
// Backpressure: none.
// Ports: wdata (right-justified store data), n_beats (1/2/4), cnt, lane_byte.
module dmem_byte_lane_mux (
    input  logic [31:0] wdata,
    input  logic [2:0]  n_beats,
    input  logic [1:0]  cnt,
    output logic [7:0]  lane_byte
);
    logic [2:0] lane;

    // Beat 0 carries the most significant byte of the right-justified data.
    always_comb begin
        lane = n_beats - 3'd1 - {1'b0, cnt};
        case (lane)
            3'd0:    lane_byte = wdata[7:0];
            3'd1:    lane_byte = wdata[15:8];
            3'd2:    lane_byte = wdata[23:16];
            3'd3:    lane_byte = wdata[31:24];
            default: lane_byte = 8'h00;
        endcase
    end
endmodule

// File: rtl/dmem_word_sequencer.sv
// Splits byte/half/word requests into 1/2/4 single-byte memory beats, big-endian.
// Latency: accept to resp_valid is N+1 cycles (1 cycle for rejected requests).
// Backpressure: req_ready high only in IDLE; busy = ~req_ready stalls the pipeline.
// Ports: CLK, RST_N (async active-low), bus (dmem_word_sequencer_if.slave).
// Build option: DMEM_ALIGN_CHECK_EN rejects misaligned half/word requests.
module dmem_word_sequencer
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    dmem_word_sequencer_if.slave bus
);
    localparam logic [31:0] WE_GUARD = 32'd1 << MEM_WE_GUARD_BIT;

    state_t            state;
    logic [ADDR_W-1:0] base_r;
    logic              wr_r;
    logic [31:0]       wdata_r;
    logic [2:0]        n_r;
    logic [1:0]        cnt_r;
    logic              err_r;
    logic [31:0]       asm_r;

    logic              req_ready_r;
    logic              resp_valid_r;
    logic [31:0]       resp_rdata_r;
    logic              resp_err_r;
    logic              mem_write_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;

    logic [2:0]        req_n;
    logic [ADDR_W:0]   end_addr;
    logic              out_of_range;
    logic              misalign;
    logic              req_err;
    logic [1:0]        cnt_nxt;
    logic              last_beat;
    logic [31:0]       lane_wdata;
    logic [2:0]        lane_n;
    logic [1:0]        lane_cnt;
    logic [7:0]        lane_byte;

    assign req_n = beat_count(bus.req_size);

    // One extra bit so a request straddling 2^ADDR_W cannot wrap past the check.
    assign end_addr     = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_n - 3'd1);
    assign out_of_range = end_addr >= (ADDR_W+1)'(MEM_BYTES);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                      ((bus.req_size[1]) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err   = out_of_range | misalign;
    assign cnt_nxt   = cnt_r + 2'd1;
    assign last_beat = ({1'b0, cnt_r} == (n_r - 3'd1));

    // Memory outputs are registered one beat ahead: at accept the lane comes
    // from the live request, during XFER from the latched one at cnt+1.
    always_comb begin
        lane_wdata = wdata_r;
        lane_n     = n_r;
        lane_cnt   = cnt_nxt;
        if (state == ST_IDLE) begin
            lane_wdata = bus.req_wdata;
            lane_n     = req_n;
            lane_cnt   = 2'd0;
        end
    end

    dmem_byte_lane_mux u_lane_mux (
        .wdata     (lane_wdata),
        .n_beats   (lane_n),
        .cnt       (lane_cnt),
        .lane_byte (lane_byte)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            base_r       <= '0;
            wr_r         <= 1'b0;
            wdata_r      <= '0;
            n_r          <= 3'd1;
            cnt_r        <= 2'd0;
            err_r        <= 1'b0;
            asm_r        <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        base_r       <= bus.req_addr;
                        wr_r         <= bus.req_write;
                        wdata_r      <= bus.req_wdata;
                        n_r          <= req_n;
                        cnt_r        <= 2'd0;
                        err_r        <= req_err;
                        asm_r        <= '0;
                        req_ready_r  <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= '0;
                        if (req_err) begin
                            // Rejected: memory outputs stay untouched.
                            state <= ST_RESP;
                        end else begin
                            state       <= ST_XFER;
                            mem_addr_r  <= bus.req_addr;
                            mem_write_r <= bus.req_write;
                            mem_wdata_r <= bus.req_write ? (WE_GUARD | {24'd0, lane_byte}) : 32'd0;
                        end
                    end
                end
                ST_XFER: begin
                    if (!wr_r) begin
                        asm_r <= {asm_r[23:0], bus.mem_rdata};
                    end
                    if (last_beat) begin
                        state       <= ST_RESP;
                        mem_write_r <= 1'b0;
                    end else begin
                        cnt_r       <= cnt_nxt;
                        mem_addr_r  <= base_r + ADDR_W'(cnt_nxt);
                        mem_wdata_r <= wr_r ? (WE_GUARD | {24'd0, lane_byte}) : 32'd0;
                    end
                end
                ST_RESP: begin
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= err_r;
                    resp_rdata_r <= (wr_r || err_r) ? 32'd0 : asm_r;
                    req_ready_r  <= 1'b1;
                    mem_write_r  <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.busy       = ~req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_write  = mem_write_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;

endmodule
